// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: FSM states and the x0 register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID-stage read of the register a load in EX is about to write.
// Purely combinational; writes to x0 never create a hazard.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_mem_re_i,
    input  logic [4:0] ex_rd_addr_i,
    input  logic [4:0] id_rs1_addr_i,
    input  logic [4:0] id_rs2_addr_i,
    input  logic       id_rs1_re_i,
    input  logic       id_rs2_re_i,
    output logic       load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i);
    assign load_use_o = ex_mem_re_i && (ex_rd_addr_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates jump, load-use, bus-wait and mul/div stalls into hold/flush/freeze/redirect.
// Control outputs are combinational from state and inputs; wait tracking, timeout and stall counter are registered.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYC = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jump_en_i,
    input  logic [31:0]      jump_addr_i,
    input  logic             ex_mem_re_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_rs1_re_i,
    input  logic             id_rs2_re_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             md_start_i,
    input  logic             md_done_i,
    output logic             jump_en_o,
    output logic [31:0]      jump_addr_o,
    output logic             pc_hold_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             freeze_o,
    output logic             md_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam int                  MD_CNT_W = (MD_MAX_CYC > 1) ? $clog2(MD_MAX_CYC) : 1;
    localparam logic [MD_CNT_W-1:0] MD_LAST  = MD_CNT_W'(MD_MAX_CYC - 1);

    state_t              state_q, state_d;
    logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic                md_err_q, md_err_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic mem_stall;
    logic md_stall;

    pipe_ctrl_hazard_detect u_hazard (
        .ex_mem_re_i   (ex_mem_re_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_re_i   (id_rs1_re_i),
        .id_rs2_re_i   (id_rs2_re_i),
        .load_use_o    (load_use)
    );

    assign mem_stall = mem_req_i && !mem_ready_i;
    assign md_stall  = md_start_i && !md_done_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
            md_err_q <= md_err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        md_err_d = md_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (md_stall) begin
                    state_d  = ST_MD_WAIT;
                    md_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready_i) state_d = ST_RUN;
            end
            ST_MD_WAIT: begin
                md_cnt_d = md_cnt_q + 1'b1;
                // A done arriving on the last allowed cycle is a success, not a timeout.
                if (md_done_i) begin
                    state_d = ST_RUN;
                end else if (md_cnt_q == MD_LAST) begin
                    state_d  = ST_RUN;
                    md_err_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        jump_en_o     = 1'b0;
        jump_addr_o   = '0;
        pc_hold_o     = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        freeze_o      = 1'b0;
        // Gated by reset so controls drop immediately even while inputs are still active.
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (mem_stall || md_stall) begin
                        freeze_o  = 1'b1;
                        pc_hold_o = 1'b1;
                    end else if (jump_en_i) begin
                        jump_en_o     = 1'b1;
                        jump_addr_o   = jump_addr_i;
                        if_id_flush_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end else if (load_use) begin
                        pc_hold_o     = 1'b1;
                        id_ex_flush_o = 1'b1;
                    end
                end
                ST_MEM_WAIT, ST_MD_WAIT: begin
                    freeze_o  = 1'b1;
                    pc_hold_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign stall_cnt_d = (pc_hold_o && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + 1'b1
                                                                      : stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign md_err_o    = md_err_q;
    assign stall_cnt_o = stall_cnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a full-width counter instance and a 4-bit counter instance share stimulus.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ex_mem_re_i;
    logic [4:0]  ex_rd_addr_i;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_re_i;
    logic        id_rs2_re_i;
    logic        mem_req_i;
    logic        mem_ready_i;
    logic        md_start_i;
    logic        md_done_i;

    logic        a_jump_en, a_pc_hold, a_if_id, a_id_ex, a_freeze, a_md_err;
    logic [31:0] a_jump_addr, a_stall;
    logic [1:0]  a_state;
    logic        b_jump_en, b_pc_hold, b_if_id, b_id_ex, b_freeze, b_md_err;
    logic [31:0] b_jump_addr;
    logic [3:0]  b_stall;
    logic [1:0]  b_state;

    int checks   = 0;
    int failures = 0;

    pipe_ctrl #(.MD_MAX_CYC(64), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_mem_re_i(ex_mem_re_i), .ex_rd_addr_i(ex_rd_addr_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .md_start_i(md_start_i), .md_done_i(md_done_i),
        .jump_en_o(a_jump_en), .jump_addr_o(a_jump_addr), .pc_hold_o(a_pc_hold),
        .if_id_flush_o(a_if_id), .id_ex_flush_o(a_id_ex), .freeze_o(a_freeze),
        .md_err_o(a_md_err), .stall_cnt_o(a_stall), .state_o(a_state)
    );

    pipe_ctrl #(.MD_MAX_CYC(64), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .ex_mem_re_i(ex_mem_re_i), .ex_rd_addr_i(ex_rd_addr_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rs1_re_i(id_rs1_re_i), .id_rs2_re_i(id_rs2_re_i),
        .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
        .md_start_i(md_start_i), .md_done_i(md_done_i),
        .jump_en_o(b_jump_en), .jump_addr_o(b_jump_addr), .pc_hold_o(b_pc_hold),
        .if_id_flush_o(b_if_id), .id_ex_flush_o(b_id_ex), .freeze_o(b_freeze),
        .md_err_o(b_md_err), .stall_cnt_o(b_stall), .state_o(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        jump_en_i     = 1'b0;
        jump_addr_i   = 32'h0;
        ex_mem_re_i   = 1'b0;
        ex_rd_addr_i  = 5'd0;
        id_rs1_addr_i = 5'd0;
        id_rs2_addr_i = 5'd0;
        id_rs1_re_i   = 1'b0;
        id_rs2_re_i   = 1'b0;
        mem_req_i     = 1'b0;
        mem_ready_i   = 1'b0;
        md_start_i    = 1'b0;
        md_done_i     = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #3;
        chk("rst_state_a", 32'(a_state), 32'd0);
        chk("rst_ctrl_a", 32'({a_jump_en, a_pc_hold, a_if_id, a_id_ex, a_freeze, a_md_err}), 32'd0);
        chk("rst_stall_a", a_stall, 32'd0);
        chk("rst_state_b", 32'(b_state), 32'd0);
        chk("rst_ctrl_b", 32'({b_jump_en, b_pc_hold, b_if_id, b_id_ex, b_freeze, b_md_err}), 32'd0);
        chk("rst_addr_b", b_jump_addr, 32'd0);
        chk("rst_stall_b", 32'(b_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Load-use through rs2.
        ex_mem_re_i = 1'b1; ex_rd_addr_i = 5'd5;
        id_rs1_addr_i = 5'd3; id_rs1_re_i = 1'b1;
        id_rs2_addr_i = 5'd5; id_rs2_re_i = 1'b1;
        #1;
        chk("lu_hold", 32'(a_pc_hold), 32'd1);
        chk("lu_id_ex", 32'(a_id_ex), 32'd1);
        chk("lu_if_id", 32'(a_if_id), 32'd0);
        chk("lu_freeze", 32'(a_freeze), 32'd0);
        tick();
        chk("lu_stall_cnt", a_stall, 32'd1);

        // Same pattern targeting x0: no hazard.
        ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0;
        #1;
        chk("lu_x0_hold", 32'(a_pc_hold), 32'd0);
        chk("lu_x0_id_ex", 32'(a_id_ex), 32'd0);
        tick();
        chk("lu_x0_cnt", a_stall, 32'd1);

        // Load-use through rs1, then the same match with rs1 not read.
        ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs2_addr_i = 5'd2;
        #1;
        chk("lu_rs1_hold", 32'(a_pc_hold), 32'd1);
        tick();
        chk("lu_rs1_cnt", a_stall, 32'd2);
        id_rs1_re_i = 1'b0;
        #1;
        chk("lu_rs1_noread", 32'(a_pc_hold), 32'd0);
        tick();

        // Jump alone, then jump with a simultaneous load-use.
        idle_inputs();
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100;
        #1;
        chk("jmp_en", 32'(a_jump_en), 32'd1);
        chk("jmp_addr", a_jump_addr, 32'h100);
        chk("jmp_flush", 32'({a_if_id, a_id_ex}), 32'b11);
        chk("jmp_hold", 32'(a_pc_hold), 32'd0);
        ex_mem_re_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_re_i = 1'b1;
        #1;
        chk("jmp_lu_hold", 32'(a_pc_hold), 32'd0);
        chk("jmp_lu_flush", 32'({a_if_id, a_id_ex}), 32'b11);
        tick();
        chk("jmp_lu_cnt", a_stall, 32'd2);
        idle_inputs();
        jump_addr_i = 32'h0000_0100;
        #1;
        chk("nojmp_addr", a_jump_addr, 32'd0);
        tick();

        // Bus wait: 3 not-ready cycles then ready; a jump arrives mid-wait.
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_req_i   = 1'b1;
            mem_ready_i = (i == 3);
            jump_en_i   = (i == 1);
            jump_addr_i = 32'h0000_0200;
            #1;
            chk("mem_freeze", 32'({a_freeze, a_pc_hold}), 32'b11);
            chk("mem_jump_blocked", 32'(a_jump_en), 32'd0);
            chk("mem_state", 32'(a_state), (i == 0) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        #1;
        chk("mem_exit_state", 32'(a_state), 32'd0);
        chk("mem_exit_freeze", 32'(a_freeze), 32'd0);
        chk("mem_stall_cnt", a_stall, 32'd6);
        chk("mem_stall_cnt_b", 32'(b_stall), 32'd6);
        mem_req_i = 1'b1; mem_ready_i = 1'b1;
        #1;
        chk("mem_ready_now", 32'({a_freeze, a_pc_hold}), 32'd0);
        tick();
        chk("mem_ready_state", 32'(a_state), 32'd0);
        idle_inputs();

        // Mul/div completing after 10 wait cycles.
        md_start_i = 1'b1;
        #1;
        chk("md_start_freeze", 32'(a_freeze), 32'd1);
        tick();
        md_start_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            md_done_i = (i == 10);
            #1;
            chk("md_wait_state", 32'(a_state), 32'd2);
            chk("md_wait_freeze", 32'(a_freeze), 32'd1);
            tick();
        end
        md_done_i = 1'b0;
        #1;
        chk("md_done_state", 32'(a_state), 32'd0);
        chk("md_done_freeze", 32'(a_freeze), 32'd0);
        chk("md_done_err", 32'(a_md_err), 32'd0);
        chk("md_stall_cnt", a_stall, 32'd17);
        chk("sat_stall_cnt_b", 32'(b_stall), 32'd15);

        // Mul/div timeout: never done.
        md_start_i = 1'b1;
        tick();
        md_start_i = 1'b0;
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) begin
                chk("md_to_last_state", 32'(a_state), 32'd2);
                chk("md_to_last_err", 32'(a_md_err), 32'd0);
            end
            tick();
        end
        chk("md_to_state", 32'(a_state), 32'd0);
        chk("md_to_err", 32'(a_md_err), 32'd1);
        chk("md_to_freeze", 32'(a_freeze), 32'd0);
        chk("md_to_cnt", a_stall, 32'd82);
        chk("md_to_cnt_b", 32'(b_stall), 32'd15);
        md_start_i = 1'b1; md_done_i = 1'b1;
        #1;
        chk("md_instant_freeze", 32'(a_freeze), 32'd0);
        tick();
        idle_inputs();
        tick();
        tick();
        chk("md_err_sticky", 32'(a_md_err), 32'd1);
        chk("md_err_sticky_b", 32'(b_md_err), 32'd1);

        // Asynchronous reset while in MD_WAIT.
        md_start_i = 1'b1;
        tick();
        md_start_i = 1'b0;
        tick();
        chk("pre_rst_state", 32'(a_state), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(a_state), 32'd0);
        chk("arst_ctrl", 32'({a_jump_en, a_pc_hold, a_if_id, a_id_ex, a_freeze}), 32'd0);
        chk("arst_err", 32'(a_md_err), 32'd0);
        chk("arst_stall", a_stall, 32'd0);
        chk("arst_stall_b", 32'(b_stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
